// File: rtl/alu_mul_ctrl.sv
// alu_mul_ctrl: 16x16 unsigned shift-and-add multiply sequenced through a shared ALU
module alu_mul_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        ovf,
  output logic        zero,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [15:0] alu_out,
  input  logic        alu_c
);
  typedef enum logic [1:0] {IDLE, SHIFT, ADD, DONE} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_mcand, r_mplier, r_acc, r_product;
  logic [3:0]  r_cnt;
  logic        r_ovf_acc, r_ovf, r_zero;
  logic        w_last;
  assign w_last  = r_cnt == 4'd0;
  assign busy    = r_state != IDLE;
  assign done    = r_state == DONE;
  assign product = r_product;
  assign ovf     = r_ovf;
  assign zero    = r_zero;
  // next state and ALU drive, derived from registered state only
  always_comb begin
    w_next  = r_state;
    alu_sel = 4'h0;
    alu_a   = '0;
    alu_b   = '0;
    case (r_state)
      IDLE:  w_next = start ? SHIFT : IDLE;
      SHIFT: begin
        alu_sel = 4'h8;
        alu_a   = r_acc;
        w_next  = r_mplier[r_cnt] ? ADD : (w_last ? DONE : SHIFT);
      end
      ADD: begin
        alu_a  = r_acc;
        alu_b  = r_mcand;
        w_next = w_last ? DONE : SHIFT;
      end
      default: w_next = IDLE;
    endcase
  end
  // state register, datapath accumulation and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= 4'd15;
      r_ovf_acc <= 1'b0;
      r_product <= '0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (start) begin
          r_mcand   <= op_a;
          r_mplier  <= op_b;
          r_acc     <= '0;
          r_cnt     <= 4'd15;
          r_ovf_acc <= 1'b0;
        end
        SHIFT: begin
          r_acc     <= alu_out;
          r_ovf_acc <= r_ovf_acc | alu_c;
          if (!r_mplier[r_cnt] && !w_last) r_cnt <= r_cnt - 4'd1;
        end
        ADD: begin
          r_acc     <= alu_out;
          r_ovf_acc <= r_ovf_acc | alu_c;
          if (!w_last) r_cnt <= r_cnt - 4'd1;
        end
        default: begin
          r_product <= r_acc;
          r_ovf     <= r_ovf_acc;
          r_zero    <= r_acc == 16'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mul_ctrl.sv
// tb_alu_mul_ctrl: randomized and directed checks of the multiply sequencer against an arithmetic model
module tb_alu_mul_ctrl;
  logic        clk = 0, rst = 1, start = 0;
  logic [15:0] op_a = 0, op_b = 0;
  logic        busy, done, ovf, zero, alu_c;
  logic [15:0] product, alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic [16:0] w_sum;
  int passed = 0, total = 0;
  int bad_sel = 0, bad_idle = 0, sel0_bnz = 0;
  logic [15:0] exp_prev = 0;

  alu_mul_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .ovf(ovf), .zero(zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_c(alu_c)
  );

  always #5 clk = ~clk;

  // the shared ALU: 4'h8 shifts A left by one, 4'h0 adds
  assign w_sum   = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_out = (alu_sel == 4'h8) ? {alu_a[14:0], 1'b0} : w_sum[15:0];
  assign alu_c   = (alu_sel == 4'h8) ? alu_a[15] : w_sum[16];

  // watch the ALU drive every cycle
  always @(negedge clk) begin
    if (alu_sel != 4'h0 && alu_sel != 4'h8) bad_sel++;
    if ((!busy || done) && (alu_a != 0 || alu_b != 0 || alu_sel != 0)) bad_idle++;
    if (alu_sel == 4'h0 && alu_b != 0) sel0_bnz++;
  end

  function automatic logic [31:0] full_prod(input logic [15:0] a, input logic [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  // issue a multiply from IDLE and return in the done cycle; lat counts edges from
  // the accept edge through the edge that closes the done cycle
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, output int lat, output logic [15:0] held);
    int n;
    op_a = a; op_b = b; start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    held = product;
    lat = n + 1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (product !== 16'h0) $display("FAIL reset_product got %h want 0000", product); else passed++;
    total++; if ({ovf, zero} !== 2'b00) $display("FAIL reset_flags got %b want 00", {ovf, zero}); else passed++;
    total++; if ({alu_a, alu_b, alu_sel} !== 36'h0) $display("FAIL reset_alu got %h want 0", {alu_a, alu_b, alu_sel}); else passed++;
    op_a = 5; op_b = 5; start = 1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL rst_beats_start got busy=%b want 0", busy); else passed++;
    rst = 0; start = 0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL start_dropped got busy=%b want 0", busy); else passed++;
    exp_prev = 0;
  endtask

  task automatic test_directed();
    logic [15:0] ta [5] = '{16'd3, 16'hFFFF, 16'h1234, 16'h0100, 16'h00FF};
    logic [15:0] tb [5] = '{16'd5, 16'hFFFF, 16'h0000, 16'h0100, 16'h0101};
    for (int i = 0; i < 5; i++) begin
      int lat, s0;
      logic [15:0] held;
      logic [31:0] f;
      f = full_prod(ta[i], tb[i]);
      s0 = sel0_bnz;
      run_mul(ta[i], tb[i], lat, held);
      total++; if (lat != 17 + $countones(tb[i])) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, 17 + $countones(tb[i])); else passed++;
      total++; if (held !== exp_prev) $display("FAIL dir%0d_held got %h want %h", i, held, exp_prev); else passed++;
      @(posedge clk); #1;
      total++; if (product !== f[15:0]) $display("FAIL dir%0d_product got %h want %h", i, product, f[15:0]); else passed++;
      total++; if (ovf !== (f > 32'hFFFF)) $display("FAIL dir%0d_ovf got %b want %b", i, ovf, f > 32'hFFFF); else passed++;
      total++; if (zero !== (f[15:0] == 0)) $display("FAIL dir%0d_zero got %b want %b", i, zero, f[15:0] == 0); else passed++;
      total++; if ({busy, done} !== 2'b00) $display("FAIL dir%0d_idle got %b want 00", i, {busy, done}); else passed++;
      if (tb[i] == 0) begin
        total++; if (sel0_bnz != s0) $display("FAIL dir%0d_no_add got %0d add-drives want 0", i, sel0_bnz - s0); else passed++;
      end
      exp_prev = f[15:0];
    end
  endtask

  task automatic test_start_ignored();
    int n, lat;
    logic [15:0] held;
    op_a = 7; op_b = 9; start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (!done && n < 40) begin
      if (n == 4) begin op_a = 16'h1111; op_b = 16'h2222; start = 1; end
      @(posedge clk); #1; n++;
      start = 0;
    end
    total++; if (n + 1 != 19) $display("FAIL ign_latency got %0d want 19", n + 1); else passed++;
    op_a = 3; op_b = 3; start = 1;
    @(posedge clk); #1;
    start = 0;
    total++; if (busy !== 1'b0) $display("FAIL ign_done_start got busy=%b want 0", busy); else passed++;
    total++; if (product !== 16'h003F) $display("FAIL ign_product got %h want 003f", product); else passed++;
    exp_prev = 16'h003F;
    run_mul(16'd3, 16'd3, lat, held);
    total++; if (lat != 19) $display("FAIL reissue_latency got %0d want 19", lat); else passed++;
    @(posedge clk); #1;
    total++; if (product !== 16'd9) $display("FAIL reissue_product got %h want 0009", product); else passed++;
    exp_prev = 16'd9;
  endtask

  task automatic test_mid_reset();
    int pulses, lat;
    logic [15:0] held;
    op_a = 16'hFFFF; op_b = 16'hFFFF; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    total++; if ({busy, done} !== 2'b00) $display("FAIL midrst_state got %b want 00", {busy, done}); else passed++;
    total++; if ({product, ovf, zero} !== 18'h0) $display("FAIL midrst_result got %h want 0", {product, ovf, zero}); else passed++;
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
    total++; if (pulses != 0) $display("FAIL midrst_no_done got %0d pulses want 0", pulses); else passed++;
    exp_prev = 0;
    run_mul(16'd2, 16'd2, lat, held);
    total++; if (lat != 18) $display("FAIL after_rst_latency got %0d want 18", lat); else passed++;
    @(posedge clk); #1;
    total++; if (product !== 16'd4) $display("FAIL after_rst_product got %h want 0004", product); else passed++;
    exp_prev = 16'd4;
  endtask

  task automatic test_back_to_back();
    int lat, n;
    logic [15:0] held, a2, b2;
    logic [31:0] f1, f2;
    a2 = 16'($urandom); b2 = 16'($urandom);
    f1 = full_prod(16'h00AB, 16'h0031);
    f2 = full_prod(a2, b2);
    run_mul(16'h00AB, 16'h0031, lat, held);
    total++; if (lat != 17 + 3) $display("FAIL b2b_lat1 got %0d want 20", lat); else passed++;
    op_a = a2; op_b = b2; start = 1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL b2b_gap got busy=%b want 0", busy); else passed++;
    total++; if (product !== f1[15:0]) $display("FAIL b2b_prod1 got %h want %h", product, f1[15:0]); else passed++;
    @(posedge clk); #1;
    start = 0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%b want 1", busy); else passed++;
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    total++; if (n + 1 != 17 + $countones(b2)) $display("FAIL b2b_lat2 got %0d want %0d", n + 1, 17 + $countones(b2)); else passed++;
    @(posedge clk); #1;
    total++; if (product !== f2[15:0]) $display("FAIL b2b_prod2 got %h want %h", product, f2[15:0]); else passed++;
    exp_prev = f2[15:0];
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int lat;
      logic [15:0] a, b, held;
      logic [31:0] f;
      a = (i % 4 == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      b = (i % 3 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      f = full_prod(a, b);
      run_mul(a, b, lat, held);
      total++; if (lat != 17 + $countones(b)) $display("FAIL rnd%0d_latency a=%h b=%h got %0d want %0d", i, a, b, lat, 17 + $countones(b)); else passed++;
      total++; if (held !== exp_prev) $display("FAIL rnd%0d_held got %h want %h", i, held, exp_prev); else passed++;
      @(posedge clk); #1;
      total++; if ({product, ovf, zero} !== {f[15:0], f > 32'hFFFF, f[15:0] == 0})
        $display("FAIL rnd%0d_result a=%h b=%h got %h/%b/%b want %h/%b/%b", i, a, b, product, ovf, zero, f[15:0], f > 32'hFFFF, f[15:0] == 0);
      else passed++;
      exp_prev = f[15:0];
    end
    total++; if (bad_sel != 0) $display("FAIL alu_sel_legal got %0d bad cycles want 0", bad_sel); else passed++;
    total++; if (bad_idle != 0) $display("FAIL alu_idle_drive got %0d bad cycles want 0", bad_idle); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
